// File: rtl/sync_r2w_level.sv
// Read-to-write pointer synchronizer with registered occupancy, almost-full flag,
// per-cycle credit return and a sticky pointer-corruption detector.
module sync_r2w_level #(
  parameter int ADDRSIZE     = 6,
  parameter int AFULL_THRESH = 60
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic [ADDRSIZE:0] rptr,
  input  logic [ADDRSIZE:0] wptr,
  input  logic              werr_clr,
  output logic [ADDRSIZE:0] wq2_rptr,
  output logic [ADDRSIZE:0] wlevel,
  output logic              walmost_full,
  output logic [ADDRSIZE:0] wfreed,
  output logic              wptr_err
);

  localparam logic [ADDRSIZE:0] FULL_LEVEL = {1'b1, {ADDRSIZE{1'b0}}};

  logic [ADDRSIZE:0] wq1_rptr_q, wq1_rptr_d;
  logic [ADDRSIZE:0] wq2_rptr_q, wq2_rptr_d;
  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              walmost_full_q, walmost_full_d;
  logic [ADDRSIZE:0] wfreed_q, wfreed_d;
  logic              wptr_err_q, wptr_err_d;
  logic [1:0]        startup_q, startup_d;

  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] wbin_s;
  logic              startup_done;
  logic              level_err;

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  always_comb begin
    wq1_rptr_d     = rptr;
    wq2_rptr_d     = wq1_rptr_q;
    rbin_s         = gray2bin(wq2_rptr_q);
    wbin_s         = gray2bin(wptr);
    startup_done   = (startup_q == 2'd3);
    startup_d      = startup_done ? startup_q : startup_q + 2'd1;
    rbin_d         = rbin_s;
    wlevel_d       = wbin_s - rbin_s;
    // The flag comes from the next level so it lines up with wlevel, not one cycle behind it.
    walmost_full_d = (32'(wlevel_d) >= AFULL_THRESH);
    // Early samples may still be settling from reset, so no credit is returned yet.
    wfreed_d       = startup_done ? (rbin_s - rbin_q) : '0;
    level_err      = startup_done && (wlevel_d > FULL_LEVEL);
    wptr_err_d     = wptr_err_q;
    if (level_err) begin
      wptr_err_d = 1'b1;
    end else if (werr_clr) begin
      wptr_err_d = 1'b0;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq1_rptr_q     <= '0;
      wq2_rptr_q     <= '0;
      rbin_q         <= '0;
      wlevel_q       <= '0;
      walmost_full_q <= 1'b0;
      wfreed_q       <= '0;
      wptr_err_q     <= 1'b0;
      startup_q      <= 2'd0;
    end else begin
      wq1_rptr_q     <= wq1_rptr_d;
      wq2_rptr_q     <= wq2_rptr_d;
      rbin_q         <= rbin_d;
      wlevel_q       <= wlevel_d;
      walmost_full_q <= walmost_full_d;
      wfreed_q       <= wfreed_d;
      wptr_err_q     <= wptr_err_d;
      startup_q      <= startup_d;
    end
  end

  assign wq2_rptr     = wq2_rptr_q;
  assign wlevel       = wlevel_q;
  assign walmost_full = walmost_full_q;
  assign wfreed       = wfreed_q;
  assign wptr_err     = wptr_err_q;

endmodule

// File: tb/tb_sync_r2w_level.sv
// Bench for sync_r2w_level: directed vector table, randomized pointer traffic
// against a history-based reference model, and a mid-stream reset sequence.
module tb_sync_r2w_level;

  logic       wclk;
  logic       wrst_n;
  logic [6:0] rptr;
  logic [6:0] wptr;
  logic       werr_clr;
  logic [6:0] wq2_rptr;
  logic [6:0] wlevel;
  logic       walmost_full;
  logic [6:0] wfreed;
  logic       wptr_err;

  int errors;
  int checks;

  sync_r2w_level #(.ADDRSIZE(6), .AFULL_THRESH(60)) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .rptr        (rptr),
    .wptr        (wptr),
    .werr_clr    (werr_clr),
    .wq2_rptr    (wq2_rptr),
    .wlevel      (wlevel),
    .walmost_full(walmost_full),
    .wfreed      (wfreed),
    .wptr_err    (wptr_err)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic [6:0] rptr;
    logic [6:0] wptr;
    logic       clr;
    logic [6:0] e_wq2;
    int         e_lvl;
    logic       e_af;
    int         e_freed;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  // Reference model: every rptr sample taken on an edge since reset release.
  logic [6:0] hist[$];
  int         n_edges;
  logic [6:0] m_wq2;
  int         m_lvl;
  logic       m_af;
  int         m_freed;
  logic       m_err;

  function automatic vec_t mk(input logic [6:0] r, input logic [6:0] w, input logic c,
                              input logic [6:0] q2, input int l, input logic af,
                              input int f, input logic e);
    vec_t v;
    v.rptr = r; v.wptr = w; v.clr = c;
    v.e_wq2 = q2; v.e_lvl = l; v.e_af = af; v.e_freed = f; v.e_err = e;
    return v;
  endfunction

  function automatic int g2b(input logic [6:0] g);
    for (int b = 0; b < 128; b++) begin
      if (7'(b ^ (b >> 1)) == g) return b;
    end
    return 0;
  endfunction

  function automatic logic [6:0] b2g(input int b);
    return 7'((b & 127) ^ ((b & 127) >> 1));
  endfunction

  function automatic logic [6:0] g_at(input int k);
    if (k >= 1) return hist[k-1];
    return 7'h00;
  endfunction

  task automatic modelReset();
    hist.delete();
    n_edges = 0;
    m_err   = 1'b0;
  endtask

  task automatic modelStep(input logic [6:0] r, input logic [6:0] w, input logic c);
    int rprev;
    int rprev2;
    n_edges++;
    hist.push_back(r);
    m_wq2   = g_at(n_edges - 1);
    rprev   = g2b(g_at(n_edges - 2));
    rprev2  = g2b(g_at(n_edges - 3));
    m_lvl   = (g2b(w) - rprev + 128) % 128;
    m_af    = (m_lvl >= 60);
    m_freed = (n_edges <= 3) ? 0 : (rprev - rprev2 + 128) % 128;
    if (n_edges >= 4 && m_lvl > 64) m_err = 1'b1;
    else if (c) m_err = 1'b0;
  endtask

  task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] q2, input int l,
                             input logic af, input int f, input logic e);
    checkVal({tag, "_wq2_rptr"}, 32'(wq2_rptr), 32'(q2));
    checkVal({tag, "_wlevel"}, 32'(wlevel), 32'(l));
    checkVal({tag, "_walmost_full"}, 32'(walmost_full), 32'(af));
    checkVal({tag, "_wfreed"}, 32'(wfreed), 32'(f));
    checkVal({tag, "_wptr_err"}, 32'(wptr_err), 32'(e));
  endtask

  task automatic applyStimulus(input logic [6:0] r, input logic [6:0] w, input logic c);
    rptr     = r;
    wptr     = w;
    werr_clr = c;
    @(posedge wclk);
    modelStep(r, w, c);
    #1;
  endtask

  initial begin
    int rb;
    int wb;
    int occ;
    int adv;
    logic [6:0] rdrv;
    logic       clr;

    errors = 0;
    checks = 0;
    modelReset();

    // Hand-derived vectors: startup, credit return, full, wrap, corruption, clear-vs-set.
    vecs.push_back(mk(7'h00, 7'h07, 0, 7'h00,   5, 0,   0, 0));
    vecs.push_back(mk(7'h00, 7'h07, 0, 7'h00,   5, 0,   0, 0));
    vecs.push_back(mk(7'h00, 7'h07, 0, 7'h00,   5, 0,   0, 0));
    vecs.push_back(mk(7'h00, 7'h07, 0, 7'h00,   5, 0,   0, 0));
    vecs.push_back(mk(7'h02, 7'h07, 0, 7'h00,   5, 0,   0, 0));
    vecs.push_back(mk(7'h02, 7'h07, 0, 7'h02,   5, 0,   0, 0));
    vecs.push_back(mk(7'h02, 7'h07, 0, 7'h02,   2, 0,   3, 0));
    vecs.push_back(mk(7'h02, 7'h07, 0, 7'h02,   2, 0,   0, 0));
    vecs.push_back(mk(7'h00, 7'h60, 0, 7'h02,  61, 1,   0, 0));
    vecs.push_back(mk(7'h00, 7'h60, 0, 7'h00,  61, 1,   0, 0));
    vecs.push_back(mk(7'h00, 7'h60, 0, 7'h00,  64, 1, 125, 0));
    vecs.push_back(mk(7'h00, 7'h60, 0, 7'h00,  64, 1,   0, 0));
    vecs.push_back(mk(7'h41, 7'h03, 0, 7'h00,   2, 0,   0, 0));
    vecs.push_back(mk(7'h41, 7'h03, 0, 7'h41,   2, 0,   0, 0));
    vecs.push_back(mk(7'h41, 7'h03, 0, 7'h41,   4, 0, 126, 0));
    vecs.push_back(mk(7'h41, 7'h03, 0, 7'h41,   4, 0,   0, 0));
    vecs.push_back(mk(7'h0F, 7'h00, 0, 7'h41,   2, 0,   0, 0));
    vecs.push_back(mk(7'h0F, 7'h00, 0, 7'h0F,   2, 0,   0, 0));
    vecs.push_back(mk(7'h0F, 7'h00, 0, 7'h0F, 118, 1,  12, 1));
    vecs.push_back(mk(7'h00, 7'h00, 0, 7'h0F, 118, 1,   0, 1));
    vecs.push_back(mk(7'h00, 7'h00, 0, 7'h00, 118, 1,   0, 1));
    vecs.push_back(mk(7'h00, 7'h00, 0, 7'h00,   0, 0, 118, 1));
    vecs.push_back(mk(7'h00, 7'h00, 1, 7'h00,   0, 0,   0, 0));
    vecs.push_back(mk(7'h00, 7'h00, 0, 7'h00,   0, 0,   0, 0));
    vecs.push_back(mk(7'h0F, 7'h00, 0, 7'h00,   0, 0,   0, 0));
    vecs.push_back(mk(7'h0F, 7'h00, 0, 7'h0F,   0, 0,   0, 0));
    vecs.push_back(mk(7'h0F, 7'h00, 1, 7'h0F, 118, 1,  10, 1));
    vecs.push_back(mk(7'h00, 7'h00, 1, 7'h0F, 118, 1,   0, 1));

    wrst_n   = 1'b0;
    rptr     = 7'h00;
    wptr     = 7'h07;
    werr_clr = 1'b0;
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    checkOutput("reset", 7'h00, 0, 1'b0, 0, 1'b0);
    wrst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rptr, vecs[i].wptr, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_wq2, vecs[i].e_lvl,
                  vecs[i].e_af, vecs[i].e_freed, vecs[i].e_err);
    end

    // Random traffic: legal multi-step advances with occasional corrupted read pointers.
    rb = 0;
    wb = 0;
    for (int i = 0; i < 400; i++) begin
      occ = (wb - rb + 128) % 128;
      adv = $urandom_range(0, 3);
      if (adv > occ) adv = occ;
      rb = (rb + adv) % 128;
      occ = (wb - rb + 128) % 128;
      adv = $urandom_range(0, 4);
      if (adv > 64 - occ) adv = 64 - occ;
      wb = (wb + adv) % 128;
      rdrv = b2g(rb);
      if ($urandom_range(0, 19) == 0) rdrv = 7'($urandom_range(0, 127));
      clr = ($urandom_range(0, 7) == 0);
      applyStimulus(rdrv, b2g(wb), clr);
      checkOutput($sformatf("rnd%0d", i), m_wq2, m_lvl, m_af, m_freed, m_err);
    end

    // Reset in the middle of traffic with a wrapped read pointer.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(7'h41, 7'h03, 1'b0);
      checkOutput($sformatf("pre%0d", i), m_wq2, m_lvl, m_af, m_freed, m_err);
    end
    #3;
    wrst_n = 1'b0;
    #1;
    checkOutput("midreset", 7'h00, 0, 1'b0, 0, 1'b0);
    modelReset();
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(7'h41, 7'h03, 1'b0);
      checkOutput($sformatf("post%0d", i), m_wq2, m_lvl, m_af, m_freed, m_err);
      if (i < 3) begin
        checkVal($sformatf("startup_freed%0d", i), 32'(wfreed), 32'd0);
        checkVal($sformatf("startup_err%0d", i), 32'(wptr_err), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_r2w_level.md
SYNC_R2W_LEVEL -- requirements
Module: sync_r2w_level

Interface
REQ-001 The block SHALL have parameter ADDRSIZE, default 6, meaning the FIFO address width; pointers are ADDRSIZE+1 bits.
REQ-002 The block SHALL have parameter AFULL_THRESH, default 60, meaning the occupancy at or above which walmost_full asserts.
REQ-003 The block SHALL have port wclk, input, 1 bit: write-domain clock, all state on rising edge.
REQ-004 The block SHALL have port wrst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rptr, input, ADDRSIZE+1 bits: Gray read pointer, registered in the read domain and asynchronous to wclk.
REQ-006 The block SHALL have port wptr, input, ADDRSIZE+1 bits: registered Gray write pointer, already in the wclk domain.
REQ-007 The block SHALL have port werr_clr, input, 1 bit: synchronous clear of wptr_err.
REQ-008 The block SHALL have port wq2_rptr, output, ADDRSIZE+1 bits: read pointer after two-flop synchronization; it is the pointer consumed by the write-full logic.
REQ-009 The block SHALL have port wlevel, output, ADDRSIZE+1 bits: registered write-side occupancy.
REQ-010 The block SHALL have port walmost_full, output, 1 bit: registered flag, wlevel >= AFULL_THRESH.
REQ-011 The block SHALL have port wfreed, output, ADDRSIZE+1 bits: entries freed by the reader since the previous cycle (credit return).
REQ-012 The block SHALL have port wptr_err, output, 1 bit: sticky pointer-corruption flag.

Function
REQ-013 rptr SHALL pass through exactly two flops, wq1_rptr then wq2_rptr, with no logic between rptr and the first flop.
REQ-014 Gray-to-binary conversion SHALL be bin[i] = XOR of gray[ADDRSIZE:i], applied to wq2_rptr (rbin_s) and to wptr (wbin_s).
REQ-015 Each edge SHALL register wlevel <= (wbin_s - rbin_s) modulo 2^(ADDRSIZE+1), giving 1-cycle latency from wq2_rptr/wptr and 3-edge latency from rptr.
REQ-016 walmost_full SHALL be registered on the same edge from the same next-level value; it SHALL NOT be derived from the registered wlevel.
REQ-017 The block SHALL hold register rbin_q <= rbin_s each edge, and SHALL register wfreed <= (rbin_s - rbin_q) modulo 2^(ADDRSIZE+1).
REQ-018 Wrap-around of either pointer through 2^(ADDRSIZE+1) SHALL yield correct wlevel and wfreed through modulo arithmetic alone.
REQ-019 A multi-step rptr advance between samples (rclk faster than wclk) SHALL be legal and SHALL be reported as the full step count in one wfreed value.
REQ-020 A next-level value greater than 2^ADDRSIZE SHALL set wptr_err on that edge; wptr_err SHALL remain set until werr_clr or reset.
REQ-021 If werr_clr and a new error occur on the same edge, set SHALL win.
REQ-022 wlevel == 2^ADDRSIZE (full) SHALL be legal and SHALL NOT set wptr_err.
REQ-023 A 2-bit startup counter SHALL count 0 to 3 after reset release and then saturate.
REQ-024 While the startup counter < 3, wfreed SHALL be forced to 0 and wptr_err SHALL NOT set; rbin_q and wlevel SHALL update normally.

Reset
REQ-025 Asserting wrst_n low SHALL immediately clear wq1_rptr, wq2_rptr, rbin_q, wlevel, walmost_full, wfreed, wptr_err and the startup counter, at any time including mid-operation.
REQ-026 After release, wq2_rptr SHALL reflect a stable rptr by the 2nd edge and wlevel by the 3rd edge.

Verification (ADDRSIZE=6, AFULL_THRESH=60)
REQ-027 Reset with rptr=7'h00, wptr=7'h07 -> all outputs 0 during reset; on 3rd edge after release wlevel=5, walmost_full=0, wfreed=0.
REQ-028 After startup, rptr 7'h00 -> 7'h02 (bin 3) -> wq2_rptr=7'h02 on 2nd edge; on 3rd edge wlevel decreases by 3 and wfreed=3; on 4th edge wfreed=0.
REQ-029 wptr=7'h60 (bin 64), rptr=7'h00 settled -> wlevel=64, walmost_full=1, wptr_err=0.
REQ-030 Wrap: wptr=7'h03 (bin 2), rptr=7'h41 (bin 126) -> wlevel=4, walmost_full=0, wptr_err=0.
REQ-031 Corruption: wptr=7'h00, rptr=7'h0F (bin 10) after startup -> wptr_err=1 and it stays 1 after rptr is restored; one werr_clr pulse clears it; clear coincident with a repeated error leaves it 1.
REQ-032 Reset asserted mid-stream with rptr=7'h41 -> outputs 0 immediately; after release, wfreed stays 0 for the first 3 edges with no spurious error.
